// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, one-hot instruction formats, control encodings
// and the combinational helpers used by decode_stage.
package decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int FUNC_W   = 4;
    localparam int FUNC3_W  = 3;
    localparam int DSEL_W   = 2;
    localparam int ALUOP_W  = 3;

    // One-hot format vector, bit order {J,U,B,S,I,R}; all-zero marks an unknown opcode.
    typedef logic [5:0] fmt_t;
    localparam int FMT_BIT_R = 0;
    localparam int FMT_BIT_I = 1;
    localparam int FMT_BIT_S = 2;
    localparam int FMT_BIT_B = 3;
    localparam int FMT_BIT_U = 4;
    localparam int FMT_BIT_J = 5;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD    = 3'd0,
        ALU_RTYPE  = 3'd1,
        ALU_ITYPE  = 3'd2,
        ALU_BRANCH = 3'd3,
        ALU_LUI    = 3'd4
    } alu_op_e;

    typedef enum logic [DSEL_W-1:0] {
        DSEL_ALU = 2'd0,
        DSEL_MEM = 2'd1,
        DSEL_PC4 = 2'd2
    } data_sel_e;

    typedef struct packed {
        logic      jal;
        logic      jalr;
        logic      branch;
        logic      mem_read;
        logic      mem_write;
        logic      reg_write;
        data_sel_e data_sel;
        alu_op_e   alu_op;
    } ctrl_t;

    function automatic fmt_t one_hot(input logic [6:0] opc);
        fmt_t f;
        f = '0;
        case (opc)
            OPC_OP:                       f[FMT_BIT_R] = 1'b1;
            OPC_OPIMM, OPC_LOAD, OPC_JALR: f[FMT_BIT_I] = 1'b1;
            OPC_STORE:                    f[FMT_BIT_S] = 1'b1;
            OPC_BRANCH:                   f[FMT_BIT_B] = 1'b1;
            OPC_LUI, OPC_AUIPC:           f[FMT_BIT_U] = 1'b1;
            OPC_JAL:                      f[FMT_BIT_J] = 1'b1;
            default:                      f = '0;
        endcase
        return f;
    endfunction

    // 32-bit immediate; R-type and unknown opcodes carry no immediate.
    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input fmt_t f);
        logic [31:0] imm;
        imm = '0;
        if (f[FMT_BIT_I])
            imm = {{20{inst[31]}}, inst[31:20]};
        else if (f[FMT_BIT_S])
            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        else if (f[FMT_BIT_B])
            imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        else if (f[FMT_BIT_U])
            imm = {inst[31:12], 12'b0};
        else if (f[FMT_BIT_J])
            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        return imm;
    endfunction

    function automatic ctrl_t decode_ctrl(input logic [6:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OPC_OP: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALU_RTYPE;
            end
            OPC_OPIMM: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALU_ITYPE;
            end
            OPC_LOAD: begin
                c.mem_read  = 1'b1;
                c.reg_write = 1'b1;
                c.data_sel  = DSEL_MEM;
            end
            OPC_JALR: begin
                c.jalr      = 1'b1;
                c.reg_write = 1'b1;
                c.data_sel  = DSEL_PC4;
            end
            OPC_STORE:  c.mem_write = 1'b1;
            OPC_BRANCH: begin
                c.branch = 1'b1;
                c.alu_op = ALU_BRANCH;
            end
            OPC_LUI: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALU_LUI;
            end
            OPC_AUIPC:  c.reg_write = 1'b1;
            OPC_JAL: begin
                c.jal       = 1'b1;
                c.reg_write = 1'b1;
                c.data_sel  = DSEL_PC4;
            end
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register busy bits tracking results still in flight, with three lookup ports.
// DECODE_WB_BYPASS_EN: a same-cycle write-back clear is visible to the lookups.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_set_en,
    input  logic [AW-1:0]        i_set_addr,
    input  logic                 i_clr_en,
    input  logic [AW-1:0]        i_clr_addr,
    input  logic                 i_flush_clr_en,
    input  logic [AW-1:0]        i_flush_clr_addr,
    input  logic [2:0][AW-1:0]   i_look_addr,
    output logic [2:0]           o_look_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_bit
            logic w_set;
            logic w_clr;
            // x0 can never become busy; a set beats any clear of the same bit.
            assign w_set = (gi != 0) && i_set_en && (i_set_addr == AW'(gi));
            assign w_clr = (i_clr_en && (i_clr_addr == AW'(gi))) ||
                           (i_flush_clr_en && (i_flush_clr_addr == AW'(gi)));
            assign w_busy_next[gi] = w_set || (r_busy[gi] && !w_clr);
        end

        for (gi = 0; gi < 3; gi++) begin : g_look
`ifdef DECODE_WB_BYPASS_EN
            assign o_look_busy[gi] = r_busy[i_look_addr[gi]] &&
                                     !(i_clr_en && (i_clr_addr == i_look_addr[gi]));
`else
            assign o_look_busy[gi] = r_busy[i_look_addr[gi]];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_next;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with register file, hazard scoreboard and flushable ID/EX bundle.
// DECODE_WB_BYPASS_EN: forward same-cycle write-back data to rs1/rs2 reads.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [31:0]         i_instruct,
    input  logic [XLEN-1:0]     i_currentPC,
    input  logic                i_flush,
    input  logic                i_wb_en,
    input  logic [AW-1:0]       i_wb_addr,
    input  logic [XLEN-1:0]     i_wb_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [XLEN-1:0]     o_pc,
    output logic [XLEN-1:0]     o_op1,
    output logic [XLEN-1:0]     o_op2,
    output logic [XLEN-1:0]     o_imm,
    output logic [XLEN-1:0]     o_Rdata2,
    output logic [AW-1:0]       o_rd,
    output logic                o_jal,
    output logic                o_jalr,
    output logic                o_branch,
    output logic                o_MemRead,
    output logic                o_MemWrite,
    output logic                o_RegWrite,
    output logic [DSEL_W-1:0]   o_Data_sel,
    output logic [ALUOP_W-1:0]  o_ALUop,
    output logic [FUNC_W-1:0]   o_func,
    output logic [FUNC3_W-1:0]  o_func3
);

    logic [XLEN-1:0] r_rf [NREGS];

    logic                r_valid;
    logic [XLEN-1:0]     r_pc, r_op1, r_op2, r_imm, r_rdata2;
    logic [AW-1:0]       r_rd;
    logic                r_jal, r_jalr, r_branch, r_mem_read, r_mem_write, r_reg_write;
    logic [DSEL_W-1:0]   r_data_sel;
    logic [ALUOP_W-1:0]  r_alu_op;
    logic [FUNC_W-1:0]   r_func;
    logic [FUNC3_W-1:0]  r_func3;

    fmt_t                w_fmt;
    ctrl_t               w_ctrl;
    logic [31:0]         w_imm32;
    logic [XLEN-1:0]     w_imm;
    logic [AW-1:0]       w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]     w_rs1_data, w_rs2_data;
    logic [XLEN-1:0]     w_op1, w_op2;
    logic                w_rs1_used, w_rs2_used;
    logic [2:0]          w_busy;
    logic                w_hazard;
    logic                w_xfer;
    logic                w_kill;

    assign w_fmt   = one_hot(i_instruct[6:0]);
    assign w_ctrl  = decode_ctrl(i_instruct[6:0]);
    assign w_imm32 = imm_gen(i_instruct, w_fmt);
    assign w_imm   = XLEN'(signed'(w_imm32));

    assign w_rs1 = i_instruct[15 +: AW];
    assign w_rs2 = i_instruct[20 +: AW];
    assign w_rd  = i_instruct[7 +: AW];

    always_comb begin
        w_rs1_data = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
        w_rs2_data = (w_rs2 == '0) ? '0 : r_rf[w_rs2];
`ifdef DECODE_WB_BYPASS_EN
        if (i_wb_en && (i_wb_addr == w_rs1) && (w_rs1 != '0))
            w_rs1_data = i_wb_data;
        if (i_wb_en && (i_wb_addr == w_rs2) && (w_rs2 != '0))
            w_rs2_data = i_wb_data;
`endif
    end

    assign w_op1 = (w_fmt[FMT_BIT_U] || w_fmt[FMT_BIT_J]) ? i_currentPC : w_rs1_data;
    assign w_op2 = (w_fmt[FMT_BIT_R] || w_fmt[FMT_BIT_B]) ? w_rs2_data : w_imm;

    assign w_rs1_used = w_fmt[FMT_BIT_R] || w_fmt[FMT_BIT_I] || w_fmt[FMT_BIT_S] || w_fmt[FMT_BIT_B];
    assign w_rs2_used = w_fmt[FMT_BIT_R] || w_fmt[FMT_BIT_S] || w_fmt[FMT_BIT_B];

    assign w_hazard = (w_rs1_used && w_busy[0]) ||
                      (w_rs2_used && w_busy[1]) ||
                      (w_ctrl.reg_write && (w_rd != '0) && w_busy[2]);

    assign o_ready = rst && !i_flush && (!r_valid || i_ready) && !w_hazard;
    assign w_xfer  = i_valid && o_ready;
    // Only a bundle that execute is not taking this cycle gets killed.
    assign w_kill  = i_flush && r_valid && !i_ready;

    decode_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk              (clk),
        .rst              (rst),
        .i_set_en         (w_xfer && w_ctrl.reg_write && (w_rd != '0)),
        .i_set_addr       (w_rd),
        .i_clr_en         (i_wb_en),
        .i_clr_addr       (i_wb_addr),
        .i_flush_clr_en   (w_kill && r_reg_write),
        .i_flush_clr_addr (r_rd),
        .i_look_addr      ({w_rd, w_rs2, w_rs1}),
        .o_look_busy      (w_busy)
    );

    // Register file has no reset; x0 is never written and always read as zero.
    always_ff @(posedge clk) begin
        if (i_wb_en && (i_wb_addr != '0))
            r_rf[i_wb_addr] <= i_wb_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_imm       <= '0;
            r_rdata2    <= '0;
            r_rd        <= '0;
            r_jal       <= 1'b0;
            r_jalr      <= 1'b0;
            r_branch    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
            r_data_sel  <= '0;
            r_alu_op    <= '0;
            r_func      <= '0;
            r_func3     <= '0;
        end else if (w_xfer) begin
            r_valid     <= 1'b1;
            r_pc        <= i_currentPC;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_imm       <= w_imm;
            r_rdata2    <= w_rs2_data;
            r_rd        <= w_rd;
            r_jal       <= w_ctrl.jal;
            r_jalr      <= w_ctrl.jalr;
            r_branch    <= w_ctrl.branch;
            r_mem_read  <= w_ctrl.mem_read;
            r_mem_write <= w_ctrl.mem_write;
            r_reg_write <= w_ctrl.reg_write;
            r_data_sel  <= w_ctrl.data_sel;
            r_alu_op    <= w_ctrl.alu_op;
            r_func      <= {i_instruct[30], i_instruct[14:12]};
            r_func3     <= i_instruct[14:12];
        end else if (r_valid && (i_ready || i_flush)) begin
            r_valid     <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_pc       = r_pc;
    assign o_op1      = r_op1;
    assign o_op2      = r_op2;
    assign o_imm      = r_imm;
    assign o_Rdata2   = r_rdata2;
    assign o_rd       = r_rd;
    assign o_jal      = r_jal;
    assign o_jalr     = r_jalr;
    assign o_branch   = r_branch;
    assign o_MemRead  = r_mem_read;
    assign o_MemWrite = r_mem_write;
    assign o_RegWrite = r_reg_write;
    assign o_Data_sel = r_data_sel;
    assign o_ALUop    = r_alu_op;
    assign o_func     = r_func;
    assign o_func3    = r_func3;

endmodule
